axistream_downsizer: RTL
========================

Name: axistream_downsizer

Overview:
- Sits directly downstream of the axistream_forwarder, on the TDATA/TVALID/TREADY/TLAST stream carrying accepted packets out of the packet-filter array.
- Converts the IN_WIDTH-bit (128) forwarded stream into an OUT_WIDTH-bit (32) AXI Stream for narrower sinks (DMA, MAC FIFO).
- Every input beat is treated as fully populated.
- Keeps running beat and packet statistics.

Parameters:
- IN_WIDTH, 128, input TDATA width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, output TDATA width.
- MSB_FIRST, 1, 1 = emit IN bits [IN_WIDTH-1 -: OUT_WIDTH] first (network byte order, matches packetmem layout); 0 = LSB word first.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- axi_aclk  in  1  clock, all logic rising-edge.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_TDATA  in  IN_WIDTH  wide stream data from the forwarder.
- s_TVALID  in  1  wide stream valid.
- s_TREADY  out  1  wide stream ready.
- s_TLAST  in  1  wide stream end of packet.
- m_TDATA  out  OUT_WIDTH  narrow stream data.
- m_TVALID  out  1  narrow stream valid.
- m_TREADY  in  1  narrow stream ready.
- m_TLAST  out  1  narrow stream end of packet.
- pkt_count  out  CNT_WIDTH  packets fully emitted (counts m_TLAST handshakes).
- word_count  out  CNT_WIDTH  narrow words emitted (counts m_TVALID&m_TREADY).
- busy  out  1  high while a packet is partially emitted (first word sent, last not yet).

Behaviour:
- RATIO = IN_WIDTH/OUT_WIDTH (4 at defaults); IDX_W = $clog2(RATIO), minimum 1.
- Async reset (axi_aresetn low), all immediate:
  - buffer empty; m_TVALID=0, m_TDATA=0, m_TLAST=0;
  - s_TREADY=0 while reset is asserted, 1 from the first clock after deassertion;
  - idx=0, pkt_count=0, word_count=0, busy=0.
- Reset mid-packet discards the buffered beat; no partial TLAST is ever emitted.
- Storage: one IN_WIDTH holding register, a last flag, a full flag, and the sub-word index idx.
- States:
  - EMPTY (full=0):
    - s_TREADY=1, m_TVALID=0.
    - On s_TVALID: load register and last flag, idx=0, go to FULL.
  - FULL (full=1):
    - m_TVALID=1; m_TDATA = sub-word idx (MSB_FIRST: bits [IN_WIDTH-1-idx*OUT_WIDTH -: OUT_WIDTH]).
    - m_TLAST = last & (idx==RATIO-1).
    - On m_TREADY with idx<RATIO-1: idx++.
    - On m_TREADY with idx==RATIO-1: the beat is drained.
- Pass-through on drain:
  - s_TREADY = !full | (m_TREADY & idx==RATIO-1), combinational on m_TREADY.
  - If s_TVALID is high on the draining cycle, the new beat loads in the same edge: idx=0, stay FULL.
  - Sustained rate is therefore 1 narrow word per cycle with no bubble between beats or packets.
  - Otherwise go to EMPTY.
- Latency: first narrow word is valid the cycle after the wide beat is accepted (1 cycle).
- AXI rules:
  - m_TDATA and m_TLAST are stable while m_TVALID & !m_TREADY.
  - m_TVALID never drops without a handshake.
  - No output depends combinationally on s_TVALID.
- Counters:
  - word_count increments on every narrow handshake.
  - pkt_count increments on a handshake with m_TLAST=1.
  - Both wrap modulo 2^CNT_WIDTH silently.
- busy: set on a narrow handshake with m_TLAST=0; cleared on one with m_TLAST=1.
- Single-beat packet (s_TLAST on the first beat) yields exactly RATIO words, TLAST on the last.
- Back-to-back packets: TLAST of packet n and the first word of packet n+1 appear on consecutive cycles when m_TREADY=1.

Decomposition:
- Shared package axis_pkg holds the localparams RATIO and IDX_W and a function subword(data, idx, msb_first). The forwarder/snooper benches reuse it.
- No sub-module: one holding register plus control. The statistics counters may live in an instantiable axis_stat_counter (increment-on-handshake, wrapping) shared with the snooper side.

Test Plan:
- Single beat, packet end: s_TDATA=128'h00112233_44556677_8899AABB_CCDDEEFF, s_TLAST=1, m_TREADY=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles starting 1 cycle after accept; TLAST only on the 4th; pkt_count=1, word_count=4.
- Streaming: 3-beat packet followed immediately by a 2-beat packet, s_TVALID and m_TREADY held high -> 20 consecutive valid words, no gaps; TLAST at words 12 and 20; s_TREADY low except on drain cycles.
- Backpressure: m_TREADY toggled 1,0,0,1 repeating -> m_TDATA/m_TLAST held during stalls, word order intact; a scoreboard against the forwarder's 128-bit stream matches.
- MSB_FIRST=0 with the same beat as the first scenario -> CCDDEEFF, 8899AABB, 44556677, 00112233.
- Reset mid-packet: deassert axi_aresetn after word 2 of 4 -> m_TVALID=0 and busy=0 immediately; after release the next packet starts at idx 0 and the counters read 0.
- Counter wrap: CNT_WIDTH=4, 17 single-beat packets -> pkt_count=1, word_count=4 (68 mod 16).

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI Stream width helpers for the forwarder/downsizer/snooper blocks.
// Width constants describe the default 128->32 datapath.
package axis_pkg;

  localparam int unsigned AXIS_IN_WIDTH  = 128;
  localparam int unsigned AXIS_OUT_WIDTH = 32;

  // Index width for a sub-word selector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio > 1) ? 32'($clog2(ratio)) : 32'd1;
  endfunction

  localparam int unsigned RATIO = AXIS_IN_WIDTH / AXIS_OUT_WIDTH;
  localparam int unsigned IDX_W = idx_width(RATIO);

  // Narrow word idx of a wide beat; msb_first selects network byte order.
  function automatic logic [AXIS_OUT_WIDTH-1:0] subword(
    input logic [AXIS_IN_WIDTH-1:0] data,
    input logic [IDX_W-1:0]         idx,
    input bit                       msb_first
  );
    int unsigned sel;
    sel = msb_first ? (RATIO - 32'd1 - 32'(idx)) : 32'(idx);
    return AXIS_OUT_WIDTH'(data >> (sel * AXIS_OUT_WIDTH));
  endfunction

endpackage

// File: rtl/axis_stat_counter.sv
// Free-running statistics counter: increments on each qualified handshake
// and wraps silently.
module axis_stat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count <= '0;
    end else if (i_inc) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/axistream_downsizer.sv
// Wide-to-narrow AXI Stream width converter with one holding register,
// zero-bubble beat pass-through and running beat/packet statistics.
module axistream_downsizer
  import axis_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 32,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [IN_WIDTH-1:0]  s_TDATA,
  input  logic                 s_TVALID,
  output logic                 s_TREADY,
  input  logic                 s_TLAST,
  output logic [OUT_WIDTH-1:0] m_TDATA,
  output logic                 m_TVALID,
  input  logic                 m_TREADY,
  output logic                 m_TLAST,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy
);

  localparam int unsigned SUB_RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned SUB_IDX_W = idx_width(SUB_RATIO);
  localparam logic [SUB_IDX_W-1:0] LAST_IDX = SUB_IDX_W'(SUB_RATIO - 1);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                r_state;
  logic [IN_WIDTH-1:0]   r_buf;
  logic                  r_last;
  logic                  r_tlast;
  logic                  r_busy;
  logic                  r_live;
  logic [SUB_IDX_W-1:0]  r_idx;

  logic                  w_full;
  logic                  w_at_end;
  logic                  w_out_hs;
  logic                  w_drain;
  logic                  w_load;
  logic                  w_load_tlast;
  logic [SUB_IDX_W-1:0]  w_next_idx;
  logic [IN_WIDTH-1:0]   w_shifted;

  assign w_full       = (r_state == ST_FULL);
  assign w_at_end     = (r_idx == LAST_IDX);
  assign w_next_idx   = r_idx + SUB_IDX_W'(1);
  assign w_out_hs     = w_full & m_TREADY;
  assign w_drain      = w_out_hs & w_at_end;
  assign w_load_tlast = s_TLAST & (SUB_RATIO == 1);

  // Ready is held low until the first clock after reset release.
  assign s_TREADY = r_live & (!w_full | w_drain);
  assign w_load   = s_TVALID & s_TREADY;

  assign m_TVALID = w_full;
  assign m_TLAST  = r_tlast;
  assign busy     = r_busy;

  // The holding register shifts so the outgoing word is always a fixed slice.
  generate
    if (MSB_FIRST) begin : g_msb
      assign m_TDATA   = r_buf[IN_WIDTH-1 -: OUT_WIDTH];
      assign w_shifted = r_buf << OUT_WIDTH;
    end else begin : g_lsb
      assign m_TDATA   = r_buf[OUT_WIDTH-1:0];
      assign w_shifted = r_buf >> OUT_WIDTH;
    end
  endgenerate

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= ST_EMPTY;
      r_buf   <= '0;
      r_last  <= 1'b0;
      r_tlast <= 1'b0;
      r_busy  <= 1'b0;
      r_live  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_out_hs) begin
        r_busy <= !r_tlast;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_buf   <= s_TDATA;
            r_last  <= s_TLAST;
            r_idx   <= '0;
            r_tlast <= w_load_tlast;
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (m_TREADY) begin
            if (!w_at_end) begin
              r_buf   <= w_shifted;
              r_idx   <= w_next_idx;
              r_tlast <= r_last & (w_next_idx == LAST_IDX);
            end else if (w_load) begin
              r_buf   <= s_TDATA;
              r_last  <= s_TLAST;
              r_idx   <= '0;
              r_tlast <= w_load_tlast;
            end else begin
              r_tlast <= 1'b0;
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  axis_stat_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .i_inc   (w_out_hs),
    .o_count (word_count)
  );

  axis_stat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk     (axi_aclk),
    .rst_n   (axi_aresetn),
    .i_inc   (w_out_hs & r_tlast),
    .o_count (pkt_count)
  );

endmodule
